// File: rtl/cdu_agc_pulser.sv
// CDU-to-AGC increment pulser: accumulates signed angle increments and pays them out as
// two-clock cdup/cdum pulses, one slot per 8 clocks. Define CDU_PULSER_OVF_EN for the sticky ovf flag.
module cdu_agc_pulser (
  input  logic              CLOCKH,
  input  logic              rst,
  input  logic              cnt_up,
  input  logic              cnt_dn,
  input  logic              cnt_en,
  input  logic              cnt_zero,
  output logic              cdup,
  output logic              cdum,
  output logic signed [4:0] backlog,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [2:0] {IDLE, PLUS1, PLUS2, MINUS1, MINUS2} state_t;

  state_t             state;
  state_t             state_nx;
  logic [2:0]         slot;
  logic               start_ok;
  logic               start_plus;
  logic               start_minus;
  logic signed [6:0]  sum;
  logic               sat;
  logic signed [4:0]  backlog_nx;

  always_comb begin
    start_ok    = (state == IDLE) && (slot == 3'd7) && cnt_en && !cnt_zero;
    start_plus  = start_ok && (backlog > 5'sd0);
    start_minus = start_ok && (backlog < 5'sd0);

    // Sign-extended sum leaves headroom so saturation is judged on the unclamped value.
    sum = {{2{backlog[4]}}, backlog} + {6'd0, cnt_up} - {6'd0, cnt_dn}
          - {6'd0, start_plus} + {6'd0, start_minus};
    sat = !cnt_zero && ((sum > 7'sd15) || (sum < -7'sd15));

    if (cnt_zero)
      backlog_nx = '0;
    else if (sum > 7'sd15)
      backlog_nx = 5'sd15;
    else if (sum < -7'sd15)
      backlog_nx = -5'sd15;
    else
      backlog_nx = sum[4:0];

    state_nx = state;
    case (state)
      IDLE: begin
        if (start_plus)
          state_nx = PLUS1;
        else if (start_minus)
          state_nx = MINUS1;
      end
      PLUS1:   state_nx = PLUS2;
      PLUS2:   state_nx = IDLE;
      MINUS1:  state_nx = MINUS2;
      MINUS2:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCKH) begin
    if (rst) begin
      state   <= IDLE;
      slot    <= '0;
      backlog <= '0;
      cdup    <= 1'b0;
      cdum    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      slot    <= slot + 3'd1;
      backlog <= backlog_nx;
      cdup    <= (state_nx == PLUS1) || (state_nx == PLUS2);
      cdum    <= (state_nx == MINUS1) || (state_nx == MINUS2);
      busy    <= (state_nx != IDLE);
    end
  end

`ifdef CDU_PULSER_OVF_EN
  always_ff @(posedge CLOCKH) begin
    if (rst || cnt_zero)
      ovf <= 1'b0;
    else if (sat)
      ovf <= 1'b1;
  end
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign ovf        = 1'b0;
`endif

endmodule
